// File: rtl/blink_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : blink_ctrl_if
// Purpose  : Control/status bundle between the game FSM and the blink generator.
// Revision : 1.0  initial release
// ============================================================================
interface blink_ctrl_if #(
    parameter int CNT_W = 4
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] count;
    logic             blink;
    logic             clk_blink;
    logic             on;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, count,
        input  blink, clk_blink, on, busy, done
    );

    modport slave (
        input  start, abort, count,
        output blink, clk_blink, on, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blink_ctrl
// Purpose  : LED blink sequencer: N flashes or endless flashing until abort.
// Revision : 1.0  initial release
// ============================================================================
module blink_ctrl #(
    parameter int CLK_DIV = 25_000_000,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    blink_ctrl_if.slave bus
);
    localparam int                c_PRE_W = $clog2(CLK_DIV);
    localparam logic [c_PRE_W-1:0] c_TERM  = c_PRE_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   c_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_PRE_W-1:0] r_pre;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_infinite;
    logic               r_blink;
    logic               r_clk_blink;
    logic               r_on;
    logic               r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_remaining <= '0;
            r_infinite  <= 1'b0;
            r_blink     <= 1'b0;
            r_clk_blink <= 1'b0;
            r_on        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_state     <= S_ON;
                        r_blink     <= 1'b1;
                        r_clk_blink <= 1'b1;
                        r_on        <= ~r_on;
                        r_pre       <= '0;
                        r_remaining <= bus.count;
                        r_infinite  <= (bus.count == '0);
                    end
                end
                S_ON: begin
                    // Abort outranks the phase terminal count.
                    if (bus.abort) begin
                        r_state     <= S_IDLE;
                        r_blink     <= 1'b0;
                        r_clk_blink <= 1'b0;
                        r_on        <= ~r_on;
                        r_pre       <= '0;
                    end else if (r_pre == c_TERM) begin
                        r_state     <= S_OFF;
                        r_clk_blink <= 1'b0;
                        r_on        <= ~r_on;
                        r_pre       <= '0;
                    end else begin
                        r_pre <= r_pre + c_PRE_W'(1);
                    end
                end
                S_OFF: begin
                    if (bus.abort) begin
                        r_state     <= S_IDLE;
                        r_blink     <= 1'b0;
                        r_clk_blink <= 1'b0;
                        r_on        <= ~r_on;
                        r_pre       <= '0;
                    end else if (r_pre == c_TERM) begin
                        r_on  <= ~r_on;
                        r_pre <= '0;
                        if (!r_infinite && r_remaining == c_ONE) begin
                            r_state <= S_IDLE;
                            r_blink <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_ON;
                            r_clk_blink <= 1'b1;
                            if (!r_infinite) begin
                                r_remaining <= r_remaining - c_ONE;
                            end
                        end
                    end else begin
                        r_pre <= r_pre + c_PRE_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_blink     <= 1'b0;
                    r_clk_blink <= 1'b0;
                    r_pre       <= '0;
                end
            endcase
        end
    end

    assign bus.blink     = r_blink;
    assign bus.clk_blink = r_clk_blink;
    assign bus.on        = r_on;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_blink_ctrl
// Purpose  : Directed scoreboard bench for blink_ctrl with CLK_DIV=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_blink_ctrl;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blink_ctrl_if #(.CNT_W(4)) bus ();

    blink_ctrl #(.CLK_DIV(D), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Per-cycle expectation: {blink, clk_blink, busy, done, on_toggled}
    typedef struct {
        logic [4:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    logic prev_on;

    function automatic void push(input string tag, input logic b, input logic cb,
                                 input logic bz, input logic dn, input logic tg);
        exp_t e;
        e.v   = {b, cb, bz, dn, tg};
        e.tag = tag;
        sb.push_back(e);
    endfunction

    // Cycle c (1-based) after an accepted start: ON for D cycles, OFF for D cycles.
    function automatic void push_active(input string tag, input int n);
        for (int c = 1; c <= n; c++)
            push(tag, 1'b1, (((c - 1) / D) % 2) == 0, 1'b1, 1'b0, ((c - 1) % D) == 0);
    endfunction

    function automatic void push_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) push(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic direct(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, then compare the next cycle's outputs.
    task automatic cycle(input logic s, input logic a, input logic [3:0] cnt);
        exp_t       e;
        logic [4:0] obs;
        bus.start = s;
        bus.abort = a;
        bus.count = cnt;
        @(posedge clk);
        #1;
        obs     = {bus.blink, bus.clk_blink, bus.busy, bus.done, bus.on ^ prev_on};
        prev_on = bus.on;
        if (sb.size() == 0) begin
            e.v   = 'x;
            e.tag = "scoreboard_underflow";
        end else begin
            e = sb.pop_front();
        end
        checks++;
        assert (obs === e.v) passed++;
        else $error("FAIL %s chk%0d: observed %b expected %b", e.tag, checks, obs, e.v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.count = '0;
        prev_on   = 1'b0;

        #2;
        direct("reset_state", {bus.blink, bus.clk_blink, bus.on, bus.busy, bus.done, 1'b0}, 6'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        prev_on = bus.on;

        push_idle("idle", 2);
        cycle(1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 4'd0);

        // Two flashes; count changes after start must not matter.
        push_active("normal", 16);
        push("normal_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_idle("normal_after", 1);
        cycle(1'b1, 1'b0, 4'd2);
        for (int i = 1; i < 18; i++) cycle(1'b0, 1'b0, 4'd9);

        // Start during a running single flash is ignored.
        push_active("ignored", 8);
        push("ignored_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_idle("ignored_after", 1);
        cycle(1'b1, 1'b0, 4'd1);
        for (int k = 1; k < 10; k++) cycle(k == 6, 1'b0, (k == 6) ? 4'd7 : 4'd1);

        push_idle("start_abort_idle", 3);
        cycle(1'b1, 1'b1, 4'd3);
        cycle(1'b0, 1'b0, 4'd3);
        cycle(1'b0, 1'b0, 4'd3);

        push_active("abort_on", 2);
        push("abort_on_exit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_idle("abort_on_after", 1);
        cycle(1'b1, 1'b0, 4'd3);
        cycle(1'b0, 1'b0, 4'd3);
        cycle(1'b0, 1'b1, 4'd3);
        cycle(1'b0, 1'b0, 4'd3);

        // Endless mode: more than 10 periods, then abort in an OFF phase.
        push_active("infinite", 85);
        push("infinite_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_idle("infinite_after", 1);
        cycle(1'b1, 1'b0, 4'd0);
        for (int k = 1; k < 87; k++) cycle(1'b0, k == 85, 4'd0);

        // Restart on the done cycle.
        push_active("b2b_first", 8);
        push("b2b_first_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_active("b2b_second", 8);
        push("b2b_second_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_idle("b2b_after", 1);
        cycle(1'b1, 1'b0, 4'd1);
        for (int k = 1; k < 9; k++) cycle(1'b0, 1'b0, 4'd1);
        cycle(1'b1, 1'b0, 4'd1);
        for (int k = 10; k < 19; k++) cycle(1'b0, 1'b0, 4'd1);

        // Asynchronous reset in the middle of an ON phase.
        push_active("pre_reset", 2);
        cycle(1'b1, 1'b0, 4'd2);
        cycle(1'b0, 1'b0, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        direct("async_reset", {bus.blink, bus.clk_blink, bus.on, bus.busy, bus.done, 1'b0}, 6'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        prev_on = 1'b0;
        push_idle("post_reset", 2);
        cycle(1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 4'd0);
        direct("post_reset_on", {5'b0, bus.on}, 6'b0);

        checks++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
